mult_datapath: RTL and testbench
================================

Name: mult_datapath

Overview:
- Register/arithmetic datapath for the 8-bit signed shift-add multiplier. It sits directly downstream of the multiplier control FSM.
- It consumes that FSM's one-hot-per-cycle strobes (clear/load, add, subtract, shift, count enable).
- It returns the multiplier LSB (M) and the iteration counter (count) that the FSM branches on.
- It holds X (sign extension), A (upper product) and B (multiplier, then lower product); the 16-bit result ends in A:B.

Parameters:
- WIDTH, 8, operand width in bits; the product is 2*WIDTH bits.
- CNT_W, $clog2(WIDTH) (= 3), iteration counter width.

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- S  in  WIDTH  switch operand: multiplicand for add/sub, multiplier for load.
- ClearAX_LoadB  in  1  clear X, A and count; load B <= S.
- Ld_XA  in  1  add: {X,A} <= sext(A) + sext(S).
- Sub  in  1  subtract: {X,A} <= sext(A) - sext(S).
- Shift_En  in  1  arithmetic right shift of X:A:B by one.
- CntEn  in  1  increment count.
- M  out  1  B[0], combinational from the B register.
- count  out  CNT_W  iteration counter (registered).
- Aval  out  WIDTH  A register (product high byte).
- Bval  out  WIDTH  B register (product low byte).
- X  out  1  sign-extension flop.

Behaviour:
- Reset=1 at a clock edge: X=0, A=0, B=0, count=0. This overrides every strobe, including reset mid-multiply.
- Register-update priority when strobes coincide: Reset > ClearAX_LoadB > Sub > Ld_XA > Shift_En.
  - Only the highest-priority active strobe updates X/A/B in a given cycle.
  - The FSM never asserts more than one of these together; the priority defines the behaviour if it does.
- ClearAX_LoadB: X<=0, A<=0, B<=S, count<=0. It overrides CntEn.
- Ld_XA: 9-bit sum T = {A[7],A} + {S[7],S}; A<=T[7:0], X<=T[8]. B and count are unchanged.
- Sub: T = {A[7],A} + ~{S[7],S} + 1, i.e. a single adder with invert plus carry-in; A<=T[7:0], X<=T[8]. B is unchanged.
- Shift_En, applied as a single shift of the 17-bit X:A:B:
  - X keeps its value.
  - A <= {X, A[7:1]}.
  - B <= {A[0], B[7:1]}.
- Overflow out of bit 8 of T is discarded. The 9-bit sign extension guarantees a correct signed product for every operand pair, including -128 * -128.
- CntEn, when not overridden by Reset or ClearAX_LoadB: count <= count + 1 modulo 2^CNT_W (7 wraps to 0).
  - CntEn is independent of the register strobes, so shift and increment occur in the same cycle.
- M = B[0] with zero latency, so the FSM sees the next multiplier bit in the cycle after each shift.
- Aval, Bval, X and count reflect the registers directly; there is no output pipelining.
- Expected operation, driven by the FSM:
  - One load cycle.
  - Then WIDTH iterations of optional add (iterations 0..6), or optional subtract (iteration 7, the sign bit), each followed by shift plus count.
  - After the 8th shift, A:B holds the signed 16-bit product and count has wrapped to 0.
- With no strobe active, all registers hold.
- S may change at any time. It is sampled only on edges where load, add or sub is active.

Decomposition:
- Package mult_pkg:
  - WIDTH and CNT_W constants.
  - An optional enum of the strobe set, used by the bench.
- Sub-module adder_sub9: combinational 9-bit add/subtract.
  - Inputs: a[8:0], b[8:0], sub.
  - Output: sum[8:0].
  - Implemented as ripple-carry full adders with b XOR sub and carry-in = sub.
- Registers (X, A and B shift registers), counter and priority mux live in mult_datapath.

Test Plan:
- Reset, then load S=0x07, then run the FSM-equivalent sequence with multiplicand S=0x03 -> A:B=0x0015 (21), X=0, count=0 after 8 shifts. M follows 1,1,1,0,... across iterations.
- Multiplier 0xFF, multiplicand 0xFF (-1 * -1) -> 7 adds and a final subtract; A:B=0x0001, X=0.
- Multiplier 0x80, multiplicand 0x80 (-128 * -128) -> only the final subtract fires; A:B=0x4000, X=0. This checks the 9-bit extension.
- Multiplier 0x01, multiplicand 0x80 (1 * -128) -> A:B=0xFF80, X=1 during the arithmetic shifts.
- Counter: assert CntEn for 9 cycles from count=0 -> 1..7, 0, 1. Assert ClearAX_LoadB and CntEn together -> count=0 and B=S.
- Reset asserted mid-multiply, at iteration 4 -> next edge X=A=B=count=0 and M=0. Sub and Ld_XA asserted together -> the subtract result wins.

Source files
------------

// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mult_pkg
// Summary  : Shared constants and strobe encoding for the shift-add multiplier.
// Revision : 1.0
// ============================================================================
package mult_pkg;

  localparam int MULT_WIDTH = 8;
  localparam int MULT_CNT_W = $clog2(MULT_WIDTH);

  // One entry per control strobe the FSM can raise on a register update.
  typedef enum logic [2:0] {
    STB_NONE  = 3'd0,
    STB_LOAD  = 3'd1,
    STB_ADD   = 3'd2,
    STB_SUB   = 3'd3,
    STB_SHIFT = 3'd4
  } strobe_e;

endpackage
`default_nettype wire

// File: rtl/adder_sub9.sv
`default_nettype none
// ============================================================================
// Module   : adder_sub9
// Summary  : Combinational ripple-carry add/subtract (b inverted, carry-in=sub).
// Revision : 1.0
// ============================================================================
module adder_sub9 #(
  parameter int N = 9
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic [N-1:0] sum
);

  logic [N-1:0] w_b_inv;
  logic [N-1:0] w_carry;

  assign w_b_inv    = b ^ {N{sub}};
  assign w_carry[0] = sub;

  for (genvar i = 0; i < N; i++) begin : g_sum
    assign sum[i] = a[i] ^ w_b_inv[i] ^ w_carry[i];
  end

  // The carry out of the top bit is discarded, so only N-1 carries propagate.
  for (genvar i = 0; i < N - 1; i++) begin : g_carry
    assign w_carry[i+1] = (a[i] & w_b_inv[i]) | (w_carry[i] & (a[i] ^ w_b_inv[i]));
  end

endmodule
`default_nettype wire

// File: rtl/mult_datapath.sv
`default_nettype none
// ============================================================================
// Module   : mult_datapath
// Summary  : X/A/B registers, iteration counter and add/sub unit of the
//            8-bit signed shift-add multiplier.
// Revision : 1.0
// ============================================================================
module mult_datapath
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] S,
  input  logic             ClearAX_LoadB,
  input  logic             Ld_XA,
  input  logic             Sub,
  input  logic             Shift_En,
  input  logic             CntEn,
  output logic             M,
  output logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] Aval,
  output logic [WIDTH-1:0] Bval,
  output logic             X
);

  logic             r_x;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH:0]   w_sum;

  // Sign-extending both operands to WIDTH+1 keeps -128 * -128 exact.
  adder_sub9 #(
    .N (WIDTH + 1)
  ) u_addsub (
    .a   ({r_a[WIDTH-1], r_a}),
    .b   ({S[WIDTH-1], S}),
    .sub (Sub),
    .sum (w_sum)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_x <= 1'b0;
      r_a <= '0;
      r_b <= '0;
    end else if (ClearAX_LoadB) begin
      r_x <= 1'b0;
      r_a <= '0;
      r_b <= S;
    end else if (Sub || Ld_XA) begin
      r_x <= w_sum[WIDTH];
      r_a <= w_sum[WIDTH-1:0];
    end else if (Shift_En) begin
      r_a <= {r_x, r_a[WIDTH-1:1]};
      r_b <= {r_a[0], r_b[WIDTH-1:1]};
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset || ClearAX_LoadB) begin
      r_count <= '0;
    end else if (CntEn) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign M     = r_b[0];
  assign count = r_count;
  assign Aval  = r_a;
  assign Bval  = r_b;
  assign X     = r_x;

endmodule
`default_nettype wire

// File: tb/tb_mult_datapath.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_datapath
// Summary  : Directed self-checking bench for mult_datapath.
// Revision : 1.0
// ============================================================================
module tb_mult_datapath;
  import mult_pkg::*;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [7:0] S;
  logic       ClearAX_LoadB, Ld_XA, Sub, Shift_En, CntEn;
  logic       M;
  logic [2:0] count;
  logic [7:0] Aval, Bval;
  logic       X;

  int tests  = 0;
  int failed = 0;

  mult_datapath dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .S             (S),
    .ClearAX_LoadB (ClearAX_LoadB),
    .Ld_XA         (Ld_XA),
    .Sub           (Sub),
    .Shift_En      (Shift_En),
    .CntEn         (CntEn),
    .M             (M),
    .count         (count),
    .Aval          (Aval),
    .Bval          (Bval),
    .X             (X)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [7:0]  mplier;
    logic [7:0]  mcand;
    logic [15:0] prod;
    logic        x;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Raise one strobe (plus optional CntEn) for exactly one rising edge.
  task automatic apply(input strobe_e stb, input logic cnt);
    ClearAX_LoadB = (stb == STB_LOAD);
    Ld_XA         = (stb == STB_ADD);
    Sub           = (stb == STB_SUB);
    Shift_En      = (stb == STB_SHIFT);
    CntEn         = cnt;
    @(posedge Clk);
    #1;
    ClearAX_LoadB = 1'b0;
    Ld_XA         = 1'b0;
    Sub           = 1'b0;
    Shift_En      = 1'b0;
    CntEn         = 1'b0;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    Reset = 1'b0;
  endtask

  // FSM-equivalent sequencing; M is checked against the loaded multiplier bits.
  task automatic run_mult(input vec_t v, input int idx);
    S = v.mplier;
    apply(STB_LOAD, 1'b0);
    S = v.mcand;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("v%0d M iter%0d", idx, i), {15'd0, M}, {15'd0, v.mplier[i]});
      if (M) apply((i == 7) ? STB_SUB : STB_ADD, 1'b0);
      apply(STB_SHIFT, 1'b1);
    end
    check($sformatf("v%0d product", idx), {Aval, Bval}, v.prod);
    check($sformatf("v%0d X", idx), {15'd0, X}, {15'd0, v.x});
    check($sformatf("v%0d count", idx), {13'd0, count}, 16'd0);
  endtask

  initial begin
    vecs[0] = '{8'h07, 8'h03, 16'h0015, 1'b0};  //    7 *    3 =     21
    vecs[1] = '{8'hFF, 8'hFF, 16'h0001, 1'b0};  //   -1 *   -1 =      1
    vecs[2] = '{8'h80, 8'h80, 16'h4000, 1'b0};  // -128 * -128 =  16384
    vecs[3] = '{8'h01, 8'h80, 16'hFF80, 1'b1};  //    1 * -128 =   -128
    vecs[4] = '{8'h05, 8'hFD, 16'hFFF1, 1'b1};  //    5 *   -3 =    -15
    vecs[5] = '{8'h7F, 8'h7F, 16'h3F01, 1'b0};  //  127 *  127 =  16129
    vecs[6] = '{8'h80, 8'h7F, 16'hC080, 1'b1};  // -128 *  127 = -16256

    Reset = 1'b0; S = 8'h00;
    ClearAX_LoadB = 1'b0; Ld_XA = 1'b0; Sub = 1'b0; Shift_En = 1'b0; CntEn = 1'b0;
    do_reset();
    check("reset A:B", {Aval, Bval}, 16'h0000);
    check("reset X/count/M", {11'd0, X, count, M}, 16'h0000);

    for (int k = 0; k < 7; k++) run_mult(vecs[k], k);

    // Hold: nothing moves with no strobe active.
    S = 8'hA5;
    repeat (3) apply(STB_NONE, 1'b0);
    check("hold A:B", {Aval, Bval}, 16'hC080);

    // Counter wrap: 1..7, 0, 1.
    do_reset();
    for (int k = 0; k < 9; k++) begin
      apply(STB_NONE, 1'b1);
      check($sformatf("count step%0d", k), {13'd0, count}, 16'((k + 1) % 8));
    end
    S = 8'h5A;
    apply(STB_LOAD, 1'b1);
    check("load+cnt count", {13'd0, count}, 16'd0);
    check("load+cnt A:B", {Aval, Bval}, 16'h005A);

    // Reset mid-multiply at iteration 4.
    S = 8'h07;
    apply(STB_LOAD, 1'b0);
    S = 8'h03;
    for (int i = 0; i < 4; i++) begin
      if (M) apply(STB_ADD, 1'b0);
      apply(STB_SHIFT, 1'b1);
    end
    Reset = 1'b1; Shift_En = 1'b1; Ld_XA = 1'b1; CntEn = 1'b1;
    @(posedge Clk);
    #1;
    Reset = 1'b0; Shift_En = 1'b0; Ld_XA = 1'b0; CntEn = 1'b0;
    check("midreset A:B", {Aval, Bval}, 16'h0000);
    check("midreset X/count/M", {11'd0, X, count, M}, 16'h0000);

    // Sub and Ld_XA together: 0 - 5 = 0x1FB.
    S = 8'h05;
    Sub = 1'b1; Ld_XA = 1'b1;
    @(posedge Clk);
    #1;
    Sub = 1'b0; Ld_XA = 1'b0;
    check("sub+add A", {8'd0, Aval}, 16'h00FB);
    check("sub+add X", {15'd0, X}, 16'd1);

    // Add beats shift: 0xFB + 0x05 = 0x100, X from 9-bit result.
    Ld_XA = 1'b1; Shift_En = 1'b1;
    @(posedge Clk);
    #1;
    Ld_XA = 1'b0; Shift_En = 1'b0;
    check("add+shift A:B", {Aval, Bval}, 16'h0000);
    check("add+shift X", {15'd0, X}, 16'd0);

    // Load beats subtract.
    S = 8'h3C;
    ClearAX_LoadB = 1'b1; Sub = 1'b1;
    @(posedge Clk);
    #1;
    ClearAX_LoadB = 1'b0; Sub = 1'b0;
    check("load+sub A:B", {Aval, Bval}, 16'h003C);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
